// File: rtl/buffer_fifo.sv
// Ready/valid FIFO with registered EMPTY/PARTIAL/FULL state and zeroed output when empty.
// Optional occupancy port: define BUFFER_FIFO_COUNT_EN to add the registered `count` output.
module buffer_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] O,
  output logic             o_valid,
  input  logic             o_ready
`ifdef BUFFER_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic            push, pop;

  // Handshake outputs depend only on registered state (plus reset for i_ready).
  assign i_ready = (state_q != FULL) && !rst;
  assign o_valid = (state_q != EMPTY);
  assign O       = o_valid ? mem_q[rd_ptr_q] : '0;

  assign push = i_valid && i_ready;
  assign pop  = o_valid && o_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Pointers wrap naturally since DEPTH is a power of two; equality decides full/empty.
    case ({push, pop})
      2'b10:   state_d = (wr_ptr_d == rd_ptr_q) ? FULL : PARTIAL;
      2'b01:   state_d = (rd_ptr_d == wr_ptr_q) ? EMPTY : PARTIAL;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the empty state hides stale words and O is forced to zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= I;
  end

`ifdef BUFFER_FIFO_COUNT_EN
  logic [AW:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_buffer_fifo.sv
// Scoreboard bench for buffer_fifo: the driver enqueues accepted words, a negedge monitor checks the head.
// Build with and without BUFFER_FIFO_COUNT_EN to cover the optional count port.
module tb_buffer_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] I;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] O;
  logic             o_valid;
  logic             o_ready;
`ifdef BUFFER_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .I       (I),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .O       (O),
    .o_valid (o_valid),
    .o_ready (o_ready)
`ifdef BUFFER_FIFO_COUNT_EN
    ,
    .count   (count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int occ    = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model is a bounded queue of accepted words.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic rs);
    bit do_push, do_pop;
    I = d; i_valid = v; o_ready = r; rst = rs;
    do_push = !rs && v && (occ < DEPTH);
    do_pop  = !rs && r && (occ > 0);
    @(posedge clk);
    #1;
    if (rs) begin
      exp_q.delete();
      occ = 0;
    end else begin
      if (do_push) exp_q.push_back(d);
      occ = occ + int'(do_push) - int'(do_pop);
    end
  endtask

  task automatic drain();
    int budget = 4 * DEPTH + 4;
    while (occ > 0 && budget > 0) begin
      step(1'b0, '0, 1'b1, 1'b0);
      budget--;
    end
    check("drain_done", 32'(occ), 32'd0);
  endtask

  // Monitor: sampled on the falling edge, between input changes and the next active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("i_ready_in_reset", 32'(i_ready), 32'd0);
      end else begin
        check("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
        check("i_ready", 32'(i_ready), 32'(exp_q.size() < DEPTH));
`ifdef BUFFER_FIFO_COUNT_EN
        check("count", 32'(count), 32'(exp_q.size()));
`endif
        if (!o_valid) begin
          check("O_zero_when_empty", 32'(O), 32'd0);
        end else if (exp_q.size() != 0) begin
          check("O_head", 32'(O), 32'(exp_q[0]));
          if (o_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    I = '0; i_valid = 1'b0; o_ready = 1'b0; rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1);

    // Single word, held at the head for five cycles with no consumer.
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    drain();

    // Fill to FULL, fifth word must be dropped.
    for (int k = 0; k < 4; k++) step(1'b1, 16'hA000 + 16'(k), 1'b0, 1'b0);
    step(1'b1, 16'hA004, 1'b0, 1'b0);
    // Pop while full with i_valid high: no push that cycle, then B000 accepted.
    step(1'b1, 16'hB000, 1'b1, 1'b0);
    step(1'b1, 16'hB000, 1'b0, 1'b0);
    drain();
    // Empty: o_ready must not underflow.
    repeat (2) step(1'b0, 16'h5555, 1'b1, 1'b0);

    // Steady state at occupancy 2 with simultaneous push and pop.
    step(1'b1, 16'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 1'b0, 1'b0);
    repeat (50) step(1'b1, 16'($urandom), 1'b1, 1'b0);
    check("steady_occ", 32'(occ), 32'd2);
    drain();

    // Reset in the middle of operation discards contents.
    for (int k = 0; k < 3; k++) step(1'b1, 16'hC000 + 16'(k), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    check("after_reset_occ", 32'(occ), 32'd1);
    drain();

    // Random traffic.
    repeat (300) step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain();
    step(1'b0, '0, 1'b0, 1'b0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
